// File: rtl/sweep_sched.sv
// Frequency-sweep learning-pass sequencer: tone load, settle, xfft reset/config, bin capture, RAM write.
// Define SWEEP_AVG2_EN to average two consecutive FFT frames per sweep step.
module sweep_sched #(
  parameter int unsigned N_STEPS    = 200,
  parameter int unsigned FFT_LEN    = 1024,
  parameter int unsigned SETTLE_CYC = 2048,
  parameter logic [15:0] FREQ_START = 16'd1,
  parameter logic [15:0] FREQ_STEP  = 16'd1,
  parameter logic [11:0] BIN_START  = 12'd1,
  parameter logic [11:0] BIN_STEP   = 12'd1,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk_1_6384m,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] freq_word,
  output logic        freq_load,
  output logic        fft_aresetn,
  output logic        fft_cfg_tvalid,
  output logic [7:0]  fft_cfg_tdata,
  input  logic        fft_cfg_tready,
  input  logic        fft_tvalid,
  input  logic        fft_tlast,
  input  logic [15:0] fft_real,
  input  logic [15:0] fft_imag,
  input  logic [7:0]  fft_blk_exp,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [15:0] wr_mag,
  output logic [7:0]  wr_exp,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned SW = $clog2(SETTLE_CYC) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SET_FREQ, S_SETTLE, S_FFT_RST, S_CONFIG, S_RUN, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t        state;
  logic [11:0]   step;
  logic [11:0]   target_bin;
  logic [11:0]   bin;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] run_cnt;
  logic          hold_cnt;
  logic [15:0]   mag_lat;
  logic [7:0]    exp_lat;

  logic [16:0] re_ext, im_ext, abs_re, abs_im, mag_sum;
  logic [15:0] mag_sat, frame_mag;
  logic [7:0]  frame_exp;
  logic        hit, last_beat, tlast_bad;

  assign fft_cfg_tdata = 8'd1;

  always_comb begin
    re_ext    = {fft_real[15], fft_real};
    im_ext    = {fft_imag[15], fft_imag};
    abs_re    = re_ext[16] ? (17'd0 - re_ext) : re_ext;
    abs_im    = im_ext[16] ? (17'd0 - im_ext) : im_ext;
    mag_sum   = abs_re + abs_im;
    mag_sat   = mag_sum[16] ? 16'hFFFF : mag_sum[15:0];
    hit       = fft_tvalid && (bin == target_bin);
    last_beat = fft_tvalid && (bin == 12'(FFT_LEN - 1));
    tlast_bad = fft_tvalid && (fft_tlast != (bin == 12'(FFT_LEN - 1)));
    // include a capture landing on the final beat itself
    frame_mag = hit ? mag_sat : mag_lat;
    frame_exp = hit ? fft_blk_exp : exp_lat;
  end

`ifdef SWEEP_AVG2_EN
  logic        second;
  logic [15:0] mag0;
  logic [16:0] avg_sum;
  logic [15:0] avg_mag;

  always_comb begin
    avg_sum = {1'b0, mag0} + {1'b0, frame_mag};
    avg_mag = 16'(avg_sum >> 1);
  end
`endif

  always_ff @(posedge clk_1_6384m) begin
    if (rst) begin
      state          <= S_IDLE;
      freq_word      <= FREQ_START;
      freq_load      <= 1'b0;
      fft_aresetn    <= 1'b0;
      fft_cfg_tvalid <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_mag         <= '0;
      wr_exp         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      step           <= '0;
      target_bin     <= BIN_START;
      bin            <= '0;
      settle_cnt     <= '0;
      run_cnt        <= '0;
      hold_cnt       <= 1'b0;
      mag_lat        <= '0;
      exp_lat        <= '0;
`ifdef SWEEP_AVG2_EN
      second         <= 1'b0;
      mag0           <= '0;
`endif
    end else if (abort) begin
      state          <= S_IDLE;
      freq_load      <= 1'b0;
      fft_aresetn    <= 1'b0;
      fft_cfg_tvalid <= 1'b0;
      wr_en          <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
      step           <= '0;
      freq_word      <= FREQ_START;
      target_bin     <= BIN_START;
    end else begin
      freq_load <= 1'b0;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state      <= S_SET_FREQ;
          freq_load  <= 1'b1;
          busy       <= 1'b1;
          err        <= 1'b0;
          step       <= '0;
          freq_word  <= FREQ_START;
          target_bin <= BIN_START;
        end
        S_SET_FREQ: begin
          state      <= S_SETTLE;
          settle_cnt <= '0;
        end
        // SET_FREQ already spent one of the SETTLE_CYC cycles
        S_SETTLE: if (settle_cnt == SW'(SETTLE_CYC - 2)) begin
          state    <= S_FFT_RST;
          hold_cnt <= 1'b0;
        end else begin
          settle_cnt <= settle_cnt + SW'(1);
        end
        S_FFT_RST: if (hold_cnt) begin
          state          <= S_CONFIG;
          fft_aresetn    <= 1'b1;
          fft_cfg_tvalid <= 1'b1;
        end else begin
          hold_cnt <= 1'b1;
        end
        S_CONFIG: if (fft_cfg_tready) begin
          state          <= S_RUN;
          fft_cfg_tvalid <= 1'b0;
          bin            <= '0;
          run_cnt        <= '0;
          mag_lat        <= '0;
          exp_lat        <= '0;
`ifdef SWEEP_AVG2_EN
          second         <= 1'b0;
`endif
        end
        S_RUN: begin
          if (tlast_bad) err <= 1'b1;
          if (fft_tvalid) bin <= bin + 12'd1;
          if (hit) begin
            mag_lat <= mag_sat;
            exp_lat <= fft_blk_exp;
          end
          run_cnt <= run_cnt + TW'(1);
          if (last_beat) begin
`ifdef SWEEP_AVG2_EN
            if (!second) begin
              second  <= 1'b1;
              mag0    <= frame_mag;
              bin     <= '0;
              run_cnt <= '0;
              mag_lat <= '0;
              exp_lat <= '0;
            end else begin
              state       <= S_WRITE;
              wr_en       <= 1'b1;
              wr_addr     <= step;
              wr_mag      <= avg_mag;
              wr_exp      <= frame_exp;
              fft_aresetn <= 1'b0;
            end
`else
            state       <= S_WRITE;
            wr_en       <= 1'b1;
            wr_addr     <= step;
            wr_mag      <= frame_mag;
            wr_exp      <= frame_exp;
            fft_aresetn <= 1'b0;
`endif
          end else if (run_cnt == TW'(TIMEOUT - 1)) begin
            err         <= 1'b1;
            state       <= S_WRITE;
            wr_en       <= 1'b1;
            wr_addr     <= step;
            wr_mag      <= '0;
            wr_exp      <= '0;
            fft_aresetn <= 1'b0;
          end
        end
        S_WRITE: state <= S_NEXT;
        S_NEXT: if (step == 12'(N_STEPS - 1)) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          state      <= S_SET_FREQ;
          freq_load  <= 1'b1;
          step       <= step + 12'd1;
          freq_word  <= freq_word + FREQ_STEP;
          target_bin <= target_bin + BIN_STEP;
        end
        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          step       <= '0;
          freq_word  <= FREQ_START;
          target_bin <= BIN_START;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_sched.sv
// Directed bench for sweep_sched: 3-step sweeps over an 8-bin FFT model, timeout, tlast error, abort.
// Expected values switch when SWEEP_AVG2_EN is defined (two frames per step).
module tb_sweep_sched;
  localparam int unsigned N_STEPS    = 3;
  localparam int unsigned FFT_LEN    = 8;
  localparam int unsigned SETTLE_CYC = 8;
  localparam int unsigned TIMEOUT    = 20;
`ifdef SWEEP_AVG2_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] freq_word;
  logic        freq_load, fft_aresetn, fft_cfg_tvalid, fft_cfg_tready;
  logic [7:0]  fft_cfg_tdata;
  logic        fft_tvalid, fft_tlast;
  logic [15:0] fft_real, fft_imag;
  logic [7:0]  fft_blk_exp;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_mag;
  logic [7:0]  wr_exp;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  sweep_sched #(
    .N_STEPS(N_STEPS), .FFT_LEN(FFT_LEN), .SETTLE_CYC(SETTLE_CYC),
    .FREQ_START(16'd100), .FREQ_STEP(16'd25),
    .BIN_START(12'd2), .BIN_STEP(12'd3), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_1_6384m(clk), .rst(rst), .start(start), .abort(abort),
    .freq_word(freq_word), .freq_load(freq_load), .fft_aresetn(fft_aresetn),
    .fft_cfg_tvalid(fft_cfg_tvalid), .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tready(fft_cfg_tready),
    .fft_tvalid(fft_tvalid), .fft_tlast(fft_tlast), .fft_real(fft_real), .fft_imag(fft_imag),
    .fft_blk_exp(fft_blk_exp), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mag(wr_mag),
    .wr_exp(wr_exp), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the tone load, check settle timing and the config handshake; leaves DUT in RUN.
  task automatic begin_step(input string tag, input logic [15:0] exp_freq);
    int n;
    n = 0;
    while (!freq_load && n < 100) begin tick(); n++; end
    chk({tag, "_load"}, freq_load, 1);
    chk({tag, "_freq"}, freq_word, exp_freq);
    n = 0;
    while (!fft_aresetn && n < 100) begin
      tick(); n++;
      if (n == 1) chk({tag, "_load_1cyc"}, freq_load, 0);
    end
    chk({tag, "_settle_cyc"}, n, SETTLE_CYC + 2);
    chk({tag, "_cfg_valid"}, fft_cfg_tvalid, 1);
    tick(); tick();
    chk({tag, "_cfg_hold"}, fft_cfg_tvalid, 1);
    fft_cfg_tready = 1'b1;
    tick();
    fft_cfg_tready = 1'b0;
    chk({tag, "_cfg_drop"}, fft_cfg_tvalid, 0);
    chk({tag, "_aresetn_run"}, fft_aresetn, 1);
  endtask

  task automatic frame(input int tgt, input logic [15:0] re, input logic [15:0] im,
                       input logic [7:0] ex, input int tlast_at);
    for (int b = 0; b < FFT_LEN; b++) begin
      fft_tvalid  = 1'b1;
      fft_real    = (b == tgt) ? re : 16'(b + 1);
      fft_imag    = (b == tgt) ? im : 16'd0;
      fft_blk_exp = ex;
      fft_tlast   = (b == tlast_at);
      tick();
    end
    fft_tvalid = 1'b0;
    fft_tlast  = 1'b0;
  endtask

  task automatic frames(input int tgt, input logic [15:0] re0, input logic [15:0] im0, input logic [7:0] ex0,
                        input logic [15:0] re1, input logic [15:0] im1, input logic [7:0] ex1,
                        input int tlast0);
    frame(tgt, re0, im0, ex0, tlast0);
    if (AVG) frame(tgt, re1, im1, ex1, FFT_LEN - 1);
  endtask

  task automatic chk_write(input string tag, input logic [11:0] a, input logic [15:0] m, input logic [7:0] e);
    chk({tag, "_wr_en"}, wr_en, 1);
    chk({tag, "_wr_addr"}, wr_addr, a);
    chk({tag, "_wr_mag"}, wr_mag, m);
    chk({tag, "_wr_exp"}, wr_exp, e);
    tick();
    chk({tag, "_wr_1cyc"}, wr_en, 0);
  endtask

  task automatic finish_pass(input string tag);
    chk({tag, "_next_nodone"}, done, 0);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    tick();
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fft_cfg_tready = 1'b0;
    fft_tvalid = 1'b0; fft_tlast = 1'b0; fft_real = '0; fft_imag = '0; fft_blk_exp = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_freq", freq_word, 16'd100);
    chk("rst_aresetn", fft_aresetn, 0);
    chk("rst_load", freq_load, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cfg_valid", fft_cfg_tvalid, 0);
    chk("cfg_tdata", fft_cfg_tdata, 8'd1);

    // Pass 1: 400/601 average, saturation, out-of-range target
    pulse_start();
    chk("p1_busy", busy, 1);
    begin_step("p1s0", 16'd100);
    frames(2, 16'd400, 16'd0, 8'h05, 16'd601, 16'd0, 8'h06, FFT_LEN - 1);
    chk_write("p1s0", 12'd0, AVG ? 16'd500 : 16'd400, AVG ? 8'h06 : 8'h05);
    begin_step("p1s1", 16'd125);
    frames(5, 16'h8000, 16'h8000, 8'h0A, 16'h8000, 16'h8000, 8'h0B, FFT_LEN - 1);
    chk_write("p1s1", 12'd1, 16'hFFFF, AVG ? 8'h0B : 8'h0A);
    begin_step("p1s2", 16'd150);
    frames(8, 16'd999, 16'd0, 8'h07, 16'd999, 16'd0, 8'h07, FFT_LEN - 1);
    chk_write("p1s2", 12'd2, 16'd0, 8'h00);
    finish_pass("p1");
    chk("p1_err", err, 0);

    // Pass 2: |re|+|im| with mixed signs, timeout at step 1
    pulse_start();
    begin_step("p2s0", 16'd100);
    frames(2, 16'hFED4, 16'd200, 8'h11, 16'hFED4, 16'd200, 8'h12, FFT_LEN - 1);
    chk_write("p2s0", 12'd0, 16'd500, AVG ? 8'h12 : 8'h11);
    chk("p2_err_pre", err, 0);
    begin_step("p2s1", 16'd125);
    n = 0;
    while (!wr_en && n < 100) begin tick(); n++; end
    chk("p2_timeout_cyc", n, TIMEOUT);
    chk("p2_timeout_err", err, 1);
    chk_write("p2s1", 12'd1, 16'd0, 8'h00);
    begin_step("p2s2", 16'd150);
    frames(8, 16'd5, 16'd5, 8'h01, 16'd5, 16'd5, 8'h01, FFT_LEN - 1);
    chk_write("p2s2", 12'd2, 16'd0, 8'h00);
    finish_pass("p2");
    chk("p2_err_sticky", err, 1);

    // Pass 3: err cleared on start, early tlast, abort in RUN
    pulse_start();
    chk("p3_err_clr", err, 0);
    begin_step("p3s0", 16'd100);
    frames(2, 16'd1000, 16'd0, 8'h21, 16'd1000, 16'd0, 8'h22, FFT_LEN - 1);
    chk_write("p3s0", 12'd0, 16'd1000, AVG ? 8'h22 : 8'h21);
    chk("p3_err_ok", err, 0);
    begin_step("p3s1", 16'd125);
    frames(5, 16'hFED4, 16'd200, 8'h31, 16'hFED4, 16'd200, 8'h31, FFT_LEN - 2);
    chk_write("p3s1", 12'd1, 16'd500, 8'h31);
    chk("p3_tlast_err", err, 1);
    begin_step("p3s2", 16'd150);
    for (int b = 0; b < 3; b++) begin
      fft_tvalid = 1'b1; fft_real = 16'(b + 1); fft_imag = '0; fft_tlast = 1'b0;
      tick();
    end
    fft_tvalid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_aresetn", fft_aresetn, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_done", done, 0);
    chk("abort_freq", freq_word, 16'd100);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_en || done || busy) seen = 1;
      tick();
    end
    chk("abort_quiet", seen, 0);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_load", freq_load, 0);
    tick();
    chk("sa_still_idle", busy, 0);

    // Pass 4: restart after abort begins at step 0
    pulse_start();
    begin_step("p4s0", 16'd100);
    frames(2, 16'd1000, 16'd0, 8'h41, 16'd1000, 16'd0, 8'h41, FFT_LEN - 1);
    chk_write("p4s0", 12'd0, 16'd1000, 8'h41);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("p4_abort_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
